// File: rtl/minilab_pkg.sv
// minilab_pkg: shared FSM state encoding and default sizing for the MAC sequencer
package minilab_pkg;
  localparam int DEF_NUM_ROWS = 8;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 32;
  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_FETCH, ST_WAIT, ST_UNPACK, ST_COMPUTE, ST_DRAIN, ST_DONE
  } state_e;
endpackage

// File: rtl/mac_sequencer.sv
// mac_sequencer: fetches B then A rows (mem_*), unpacks them into FIFOs (fifo_wren/wdata), then drives staggered fifo_rden/mac_en with busy/done/err status
module mac_sequencer
  import minilab_pkg::*;
#(
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int DEPTH = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  output logic mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic mem_waitrequest,
  input  logic mem_readdatavalid,
  input  logic [DEPTH*DATA_WIDTH-1:0] mem_readdata,
  output logic [NUM_ROWS:0] fifo_wren,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic [NUM_ROWS:0] fifo_rden,
  input  logic [NUM_ROWS:0] fifo_full,
  input  logic [NUM_ROWS:0] fifo_empty,
  output logic [NUM_ROWS-1:0] mac_en,
  output logic mac_clr
);
  localparam int RW = $clog2(NUM_ROWS + 1);
  localparam int CW = $clog2(DEPTH + NUM_ROWS);
  localparam int EW = $clog2(DEPTH + 1);
  localparam int VW = DEPTH * DATA_WIDTH;
  localparam int FW = NUM_ROWS + 1;
  state_e state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [EW-1:0] e_q, e_d;
  logic [VW-1:0] sh_q, sh_d;
  logic err_q, err_d, busy_q, busy_d, done_q, done_d;
  logic mem_read_q, mem_read_d, mac_clr_q, mac_clr_d, accepted;
  logic [NUM_ROWS:0] fifo_wren_q, fifo_wren_d, fifo_rden_q, fifo_rden_d, sel_d;
  logic [DATA_WIDTH-1:0] fifo_wdata_q, fifo_wdata_d;
  logic [NUM_ROWS-1:0] mac_en_q, mac_en_d;
  always_comb begin
    state_d = state_q;
    r_d = r_q;
    c_d = c_q;
    e_d = e_q;
    sh_d = sh_q;
    err_d = err_q || (|(fifo_rden_q & fifo_empty));
    accepted = |(fifo_wren_q & ~fifo_full);
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_CLEAR;
        r_d = '0;
        err_d = 1'b0;
      end
      ST_CLEAR: state_d = ST_FETCH;
      ST_FETCH: if (!mem_waitrequest) state_d = ST_WAIT;
      ST_WAIT: if (mem_readdatavalid) begin
        state_d = ST_UNPACK;
        sh_d = mem_readdata;
        e_d = '0;
      end
      ST_UNPACK: if (accepted) begin
        sh_d = sh_q >> DATA_WIDTH;
        e_d = e_q + 1'b1;
        if (e_q == EW'(DEPTH - 1)) begin
          state_d = (r_q == RW'(NUM_ROWS)) ? ST_COMPUTE : ST_FETCH;
          r_d = (r_q == RW'(NUM_ROWS)) ? r_q : r_q + 1'b1;
          c_d = '0;
        end
      end
      ST_COMPUTE: if (c_q == CW'(DEPTH + NUM_ROWS - 2)) state_d = ST_DRAIN;
        else c_d = c_q + 1'b1;
      ST_DRAIN: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    // outputs are registered, so they are decoded from the next state
    sel_d = FW'(1) << ((r_d == '0) ? RW'(NUM_ROWS) : r_d - 1'b1);
    busy_d = state_d != ST_IDLE;
    done_d = state_d == ST_DONE;
    mem_read_d = state_d == ST_FETCH;
    mac_clr_d = state_d == ST_CLEAR;
    fifo_wren_d = (state_d == ST_UNPACK) ? sel_d & ~fifo_full : '0;
    fifo_wdata_d = (state_d == ST_UNPACK) ? sh_d[DATA_WIDTH-1:0] : fifo_wdata_q;
    fifo_rden_d[NUM_ROWS] = state_d == ST_COMPUTE && c_d < CW'(DEPTH);
    for (int i = 0; i < NUM_ROWS; i++)
      fifo_rden_d[i] = state_d == ST_COMPUTE && int'(c_d) >= i && int'(c_d) < i + DEPTH;
    mac_en_d = fifo_rden_q[NUM_ROWS-1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      r_q <= '0;
      c_q <= '0;
      e_q <= '0;
      sh_q <= '0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mem_read_q <= 1'b0;
      mac_clr_q <= 1'b0;
      fifo_wren_q <= '0;
      fifo_wdata_q <= '0;
      fifo_rden_q <= '0;
      mac_en_q <= '0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      c_q <= c_d;
      e_q <= e_d;
      sh_q <= sh_d;
      err_q <= err_d;
      busy_q <= busy_d;
      done_q <= done_d;
      mem_read_q <= mem_read_d;
      mac_clr_q <= mac_clr_d;
      fifo_wren_q <= fifo_wren_d;
      fifo_wdata_q <= fifo_wdata_d;
      fifo_rden_q <= fifo_rden_d;
      mac_en_q <= mac_en_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign mem_read = mem_read_q;
  assign mem_addr = ADDR_WIDTH'(r_q);
  assign fifo_wren = fifo_wren_q;
  assign fifo_wdata = fifo_wdata_q;
  assign fifo_rden = fifo_rden_q;
  assign mac_en = mac_en_q;
  assign mac_clr = mac_clr_q;
endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter NUM_ROWS, default 8: number of MAC units and A-row FIFOs.
REQ-002 Parameter DEPTH, default 8: elements per vector and FIFO depth.
REQ-003 Parameter DATA_WIDTH, default 8: element width in bits.
REQ-004 Parameter ADDR_WIDTH, default 32: memory address width.
REQ-005 There SHALL be one clock; reset is synchronous and active-low (clk, rst_n).
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 start  in  1  one-cycle pulse that begins a matrix-vector job; ignored unless in IDLE.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle pulse when results are final.
REQ-011 err  out  1  sticky protocol error; cleared by an accepted start.
REQ-012 mem_read  out  1  memory read request.
REQ-013 mem_addr  out  ADDR_WIDTH  word address of the request.
REQ-014 mem_waitrequest  in  1  request not accepted this cycle.
REQ-015 mem_readdatavalid  in  1  mem_readdata valid.
REQ-016 mem_readdata  in  DEPTH*DATA_WIDTH  one full vector row.
REQ-017 fifo_wren  out  NUM_ROWS+1  one-hot write enable; index NUM_ROWS is the B FIFO.
REQ-018 fifo_wdata  out  DATA_WIDTH  shared write data to all FIFOs.
REQ-019 fifo_rden  out  NUM_ROWS+1  per-FIFO read enable.
REQ-020 fifo_full, fifo_empty  in  NUM_ROWS+1 each  FIFO status.
REQ-021 mac_en  out  NUM_ROWS  per-MAC accumulate enable.
REQ-022 mac_clr  out  1  clears all MAC accumulators.

Function
REQ-023 The FSM SHALL have these states: IDLE, CLEAR, FETCH, WAIT, UNPACK, COMPUTE, DRAIN, DONE.
REQ-024 IDLE -> CLEAR on start; CLEAR holds mac_clr=1 for exactly one cycle, then goes to FETCH with row index r=0.
REQ-025 FETCH asserts mem_read with mem_addr=r and holds both until mem_waitrequest=0, then goes to WAIT.
REQ-026 Row r=0 loads the B FIFO (index NUM_ROWS); row r=k (k>=1) loads A FIFO k-1; NUM_ROWS+1 rows are loaded in total.
REQ-027 WAIT captures mem_readdata into a DEPTH*DATA_WIDTH shift register on mem_readdatavalid, then goes to UNPACK.
REQ-028 UNPACK writes one element per cycle, least-significant element first, for DEPTH writes; the target fifo_wren bit is held low while its fifo_full=1 (the write stalls; no element is lost).
REQ-029 After the last element of row r: if r<NUM_ROWS, increment r and go to FETCH; otherwise go to COMPUTE with cycle counter c=0.
REQ-030 COMPUTE runs for exactly DEPTH+NUM_ROWS-1 cycles.
REQ-031 In COMPUTE, fifo_rden[NUM_ROWS] (B) SHALL be 1 for c<DEPTH.
REQ-032 In COMPUTE, fifo_rden[i] (A row i) SHALL be 1 for i<=c<i+DEPTH (systolic stagger).
REQ-033 mac_en[i] SHALL equal fifo_rden[i] delayed by one cycle (FIFO read latency 1).
REQ-034 DRAIN lasts one cycle and lets the final mac_en take effect; the FSM then enters DONE.
REQ-035 DONE pulses done for one cycle, then returns to IDLE.
REQ-036 fifo_rden asserted while the matching fifo_empty=1 SHALL set err; the sequence continues unchanged.
REQ-037 start while busy SHALL be ignored; start and done in the same cycle do not start a new job.
REQ-038 Counters SHALL be sized with $clog2 of their maximum and SHALL NOT wrap within a job.
REQ-039 All outputs SHALL be registered, except mem_addr, which is driven from the registered r.

Reset
REQ-040 When rst_n=0 at a clock edge, the FSM goes to IDLE and r, c, the shift register and err clear to 0.
REQ-041 Reset values: busy=0, done=0, err=0, mem_read=0, mem_addr=0, fifo_wren=0, fifo_wdata=0, fifo_rden=0, mac_en=0, mac_clr=0.
REQ-042 Reset asserted mid-job SHALL abort the job immediately; FIFO contents are not the sequencer's responsibility.

Structure
REQ-043 The state enum and the default parameters SHALL live in a shared package, minilab_pkg.
REQ-044 The design is a single module with no sub-modules; the stagger logic is comparator-based on c.

Verification
REQ-045 Nominal job, zero-wait memory, row data = address-tagged bytes -> 9 rows x 8 writes in FIFO order B, A0..A7; COMPUTE lasts 15 cycles; done arrives exactly 1 cycle after DRAIN.
REQ-046 mem_waitrequest held high for 5 cycles during FETCH r=3 -> mem_read and mem_addr=3 stable throughout; no extra requests.
REQ-047 fifo_full[2]=1 for 4 cycles during UNPACK -> fifo_wren[2] stays low, fifo_wdata is held, and all 8 elements are written afterwards.
REQ-048 fifo_empty[5]=1 at c=6 -> err=1 and stays 1; the next accepted start clears it.
REQ-049 rst_n=0 during COMPUTE at c=7 -> next cycle all outputs are at reset values; a new start runs a full job correctly.
REQ-050 start pulsed during UNPACK and in the DONE cycle -> no effect; exactly one done pulse per accepted start.
